// File: rtl/program_counter_pkg.sv
// Shared definitions for the Hack program counter stage: default sizing,
// reset address and the jump-field encodings.
package program_counter_pkg;

  localparam int              DEFAULT_WIDTH    = 16;
  localparam logic [15:0]     DEFAULT_RESET_PC = 16'h0000;

  // Bit order within the field is j1 j2 j3, meaning [2]=lt [1]=eq [0]=gt
  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

endpackage

// File: rtl/program_counter_if.sv
// Bus between the CPU core (master) and the program counter stage (slave):
// jump target, ALU flags and stall in, fetch address and status out.
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a_in;
  logic             c_instr;
  logic [2:0]       jump;
  logic             zr;
  logic             ng;
  logic             stall;
  logic [WIDTH-1:0] pc;
  logic             jump_taken;
  logic             halted;

  modport master (
    output a_in, c_instr, jump, zr, ng, stall,
    input  pc, jump_taken, halted
  );

  modport slave (
    input  a_in, c_instr, jump, zr, ng, stall,
    output pc, jump_taken, halted
  );

endinterface

// File: rtl/program_counter_jump_cond.sv
// Combinational jump decision: compares the instruction's jump field
// against the ALU sign/zero flags. A-instructions never jump.
module program_counter_jump_cond
  import program_counter_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  input  logic       c_instr,
  output logic       cond
);

  logic gt;

  assign gt   = ~zr & ~ng;
  assign cond = c_instr & ((jump[2] & ng) | (jump[1] & zr) | (jump[0] & gt));

endmodule

// File: rtl/program_counter.sv
// Hack CPU program counter: hold on stall, load A on a taken jump,
// otherwise increment; flags a taken jump and a jump-to-self halt loop.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
)(
  input  logic              clock,
  input  logic              reset,
  program_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             cond;
  logic             load;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic             jump_taken_q;
  logic             halted_q;

  program_counter_jump_cond u_jump_cond (
    .jump    (bus.jump),
    .zr      (bus.zr),
    .ng      (bus.ng),
    .c_instr (bus.c_instr),
    .cond    (cond)
  );

  // A stalled cycle drops any pending jump; upstream re-presents it later
  assign load = ~bus.stall & cond;

  always_comb begin
    pc_next = pc_q + ONE;
    if (bus.stall) begin
      pc_next = pc_q;
    end else if (cond) begin
      pc_next = bus.a_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      jump_taken_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_next;
      jump_taken_q <= load;
      if (load && (bus.a_in == pc_q)) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.jump_taken = jump_taken_q;
  assign bus.halted     = halted_q;

endmodule
